// File: rtl/mem_block_copier.sv
// -----------------------------------------------------------------------------
// mem_block_copier
//
// Memory-port initiator that copies a block of bytes from a source address to
// a destination address, one byte at a time. While it is busy the CPU is
// stalled and an external mux, selected by busy, gives this block the data
// memory port. Each byte takes two cycles: READ, where the combinational read
// data is captured, then WRITE, where the memory commits the byte.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      one-cycle copy request, sampled only in IDLE
//   abort      cancels an active copy (READ or WRITE only)
//   src_addr   first source byte address
//   dst_addr   first destination byte address
//   length     number of bytes to copy (0 completes with no memory access)
//   mem_addr   registered memory address
//   mem_wdata  registered memory write data
//   mem_we     registered memory write enable, high only in WRITE
//   mem_rdata  combinational memory read data for the current mem_addr
//   busy       high while in READ or WRITE
//   done       one-cycle pulse on normal completion
//   checksum   16-bit running sum of the copied bytes
//
// Build option:
//   MEM_BLOCK_COPIER_CHECKSUM_EN  when defined, checksum accumulates every
//   byte read during a copy (cleared on start). When undefined, checksum is
//   tied to zero and no adder is built.
// -----------------------------------------------------------------------------
module mem_block_copier #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] srcAddr;
    logic [ADDR_W-1:0] dstAddr;
    logic [LEN_W-1:0]  count;

    // Address increments rely on natural ADDR_W-bit wrap, so the top of
    // memory rolls over to address 0 for both pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            srcAddr   <= '0;
            dstAddr   <= '0;
            count     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // start takes priority over abort here; abort is only
                    // meaningful once a copy is running.
                    if (start) begin
                        if (length != '0) begin
                            srcAddr  <= src_addr;
                            dstAddr  <= dst_addr;
                            count    <= length;
                            mem_addr <= src_addr;
                            busy     <= 1'b1;
                            state    <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                READ: begin
                    if (abort) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mem_wdata <= mem_rdata;
                        mem_addr  <= dstAddr;
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    // The write presented this cycle commits at this edge
                    // regardless of abort; the memory samples mem_we now.
                    mem_we  <= 1'b0;
                    count   <= count - LEN_ONE;
                    srcAddr <= srcAddr + ADDR_ONE;
                    dstAddr <= dstAddr + ADDR_ONE;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == LEN_ONE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_addr <= srcAddr + ADDR_ONE;
                        state    <= READ;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [15:0] sumReg;

    // Modulo-2^16 accumulate of one zero-extended data byte.
    function automatic logic [15:0] accumByte(input logic [15:0]       sum,
                                              input logic [DATA_W-1:0] b);
        return sum + {{(16-DATA_W){1'b0}}, b};
    endfunction

    // Accumulates exactly the bytes latched on READ->WRITE edges; the value
    // then holds through done or abort until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sumReg <= '0;
        end else if (state == IDLE && start) begin
            sumReg <= '0;
        end else if (state == READ && !abort) begin
            sumReg <= accumByte(sumReg, mem_rdata);
        end
    end

    assign checksum = sumReg;
`else
    assign checksum = 16'h0000;
`endif

endmodule
